// File: rtl/y_seq_ctl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the y-datapath with write-strobe gating.
// Optional perf counters (cyc_count, stall_count) enabled by defining Y_SEQ_PERF_EN.
module y_seq_ctl #(
    parameter int unsigned MAX_INS = 43,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             INT,
    input  logic             go,
    input  logic             isStype,
    input  logic             isRtype,
    input  logic             isItype,
    input  logic             isLw,
    input  logic             isjump,
    input  logic             isbranch,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pc_init,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] ins_count
`ifdef Y_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StIf   = 3'd2,
        StId   = 3'd3,
        StEx   = 3'd4,
        StMem  = 3'd5,
        StWb   = 3'd6,
        StHalt = 3'd7
    } state_e;

    // Class bits: {S, R, I, lw, jump, branch}
    localparam int unsigned CS = 5, CR = 4, CI = 3, CL = 2, CJ = 1, CB = 0;

    state_e           state_q, state_d;
    logic [5:0]       class_q, class_d;
    logic [WaitW-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    logic [5:0]       flags;
    logic             retire;
    logic             pc_init_w, ir_we_w, pc_we_w, rf_we_w, mem_re_w, mem_we_w;

    assign flags    = {isStype, isRtype, isItype, isLw, isjump, isbranch};
    assign wait_inc = wait_q + WaitW'(1);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        retire    = 1'b0;
        pc_init_w = 1'b0;
        ir_we_w   = 1'b0;
        pc_we_w   = 1'b0;
        rf_we_w   = 1'b0;
        mem_re_w  = 1'b0;
        mem_we_w  = 1'b0;
        unique case (state_q)
            StIdle: if (go) state_d = StInit;
            StInit: begin
                pc_init_w = 1'b1;
                state_d   = StIf;
            end
            StIf: begin
                ir_we_w = 1'b1;
                state_d = StId;
            end
            StId: begin
                class_d = flags;
                if ($countones(flags) == 1) begin
                    state_d = StEx;
                end else begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StEx: begin
                wait_d = '0;
                if (class_q[CL] || class_q[CS]) begin
                    state_d = StMem;
                end else if (class_q[CR] || class_q[CI] || class_q[CJ]) begin
                    state_d = StWb;
                end else if (class_q[CB]) begin
                    pc_we_w = 1'b1;
                    retire  = 1'b1;
                end else begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StMem: begin
                mem_re_w = class_q[CL];
                mem_we_w = class_q[CS];
                if (mem_ready) begin
                    if (class_q[CL]) begin
                        state_d = StWb;
                    end else begin
                        pc_we_w = 1'b1;
                        retire  = 1'b1;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WaitW'(TIMEOUT)) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                end
            end
            StWb: begin
                rf_we_w = 1'b1;
                pc_we_w = 1'b1;
                retire  = 1'b1;
            end
            StHalt: state_d = StHalt;
        endcase
        if (retire) begin
            cnt_d   = cnt_inc;
            state_d = ((MAX_INS != 0) && (cnt_inc == CNT_W'(MAX_INS))) ? StHalt : StIf;
        end
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            state_q <= StIdle;
            class_q <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Every output is forced low while reset is held, including registered ones.
    assign state     = INT ? 3'd0 : state_q;
    assign pc_init   = ~INT & pc_init_w;
    assign ir_we     = ~INT & ir_we_w;
    assign pc_we     = ~INT & pc_we_w;
    assign rf_we     = ~INT & rf_we_w;
    assign mem_re    = ~INT & mem_re_w;
    assign mem_we    = ~INT & mem_we_w;
    assign busy      = ~INT & (state_q != StIdle) & (state_q != StHalt);
    assign halted    = ~INT & (state_q == StHalt);
    assign err       = ~INT & err_q;
    assign ins_count = INT ? '0 : cnt_q;

`ifdef Y_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_q, stall_q;

    always_ff @(posedge clk) begin
        if (INT) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q inside {StIf, StId, StEx, StMem, StWb}) cyc_q <= cyc_q + CNT_W'(1);
            if (state_q == StMem && !mem_ready) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign cyc_count   = INT ? '0 : cyc_q;
    assign stall_count = INT ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_y_seq_ctl.sv
// Directed bench for y_seq_ctl: vector table for reset/R/lw flow, hand sequences for
// timeout, illegal class, retire budget and mid-run reset.
module tb_y_seq_ctl;

    localparam logic [5:0] FR = 6'b010000, FL = 6'b000100, FS = 6'b100000;
    localparam logic [5:0] FB = 6'b000001, FZ = 6'b000000, F2 = 6'b011000;

    logic       clk, INT, go, mem_ready;
    logic [5:0] fl;

    logic [2:0]  a_state, b_state;
    logic        a_pc_init, a_ir_we, a_pc_we, a_rf_we, a_mem_re, a_mem_we;
    logic        a_busy, a_halted, a_err;
    logic        b_pc_init, b_ir_we, b_pc_we, b_rf_we, b_mem_re, b_mem_we;
    logic        b_busy, b_halted, b_err;
    logic [15:0] a_cnt, b_cnt;
`ifdef Y_SEQ_PERF_EN
    logic [15:0] a_cyc, a_stall, b_cyc, b_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    y_seq_ctl #(.MAX_INS(0), .TIMEOUT(15), .CNT_W(16)) u_dut_a (
        .clk(clk), .INT(INT), .go(go),
        .isStype(fl[5]), .isRtype(fl[4]), .isItype(fl[3]),
        .isLw(fl[2]), .isjump(fl[1]), .isbranch(fl[0]),
        .mem_ready(mem_ready), .state(a_state), .pc_init(a_pc_init), .ir_we(a_ir_we),
        .pc_we(a_pc_we), .rf_we(a_rf_we), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .busy(a_busy), .halted(a_halted), .err(a_err), .ins_count(a_cnt)
`ifdef Y_SEQ_PERF_EN
        , .cyc_count(a_cyc), .stall_count(a_stall)
`endif
    );

    y_seq_ctl #(.MAX_INS(3), .TIMEOUT(15), .CNT_W(16)) u_dut_b (
        .clk(clk), .INT(INT), .go(go),
        .isStype(fl[5]), .isRtype(fl[4]), .isItype(fl[3]),
        .isLw(fl[2]), .isjump(fl[1]), .isbranch(fl[0]),
        .mem_ready(mem_ready), .state(b_state), .pc_init(b_pc_init), .ir_we(b_ir_we),
        .pc_we(b_pc_we), .rf_we(b_rf_we), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .busy(b_busy), .halted(b_halted), .err(b_err), .ins_count(b_cnt)
`ifdef Y_SEQ_PERF_EN
        , .cyc_count(b_cyc), .stall_count(b_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       g;
        logic [5:0] f;
        logic       mr;
        logic [2:0] st;
        logic [5:0] sb;   // {pc_init, ir_we, pc_we, rf_we, mem_re, mem_we}
        logic [2:0] bhe;  // {busy, halted, err}
        int         cnt;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic [5:0] f, input logic mr);
        @(negedge clk);
        INT       = r;
        go        = g;
        fl        = f;
        mem_ready = mr;
        #1;
    endtask

    initial begin
        int cyc;
        int pulses;
        int memc;
        int wec;
        logic [5:0] pat[2];

        INT = 1'b1; go = 1'b0; fl = FZ; mem_ready = 1'b0;

        // Reset with go held, R-type, then lw with 3 not-ready MEM cycles (class change after ID)
        vt[0]  = '{1'b1, 1'b1, FR, 1'b0, 3'd0, 6'b000000, 3'b000, 0};
        vt[1]  = '{1'b1, 1'b1, FR, 1'b0, 3'd0, 6'b000000, 3'b000, 0};
        vt[2]  = '{1'b0, 1'b1, FR, 1'b0, 3'd0, 6'b000000, 3'b000, 0};
        vt[3]  = '{1'b0, 1'b0, FR, 1'b0, 3'd1, 6'b100000, 3'b100, 0};
        vt[4]  = '{1'b0, 1'b0, FR, 1'b0, 3'd2, 6'b010000, 3'b100, 0};
        vt[5]  = '{1'b0, 1'b0, FR, 1'b0, 3'd3, 6'b000000, 3'b100, 0};
        vt[6]  = '{1'b0, 1'b0, FR, 1'b1, 3'd4, 6'b000000, 3'b100, 0};
        vt[7]  = '{1'b0, 1'b1, FR, 1'b0, 3'd6, 6'b001100, 3'b100, 0};
        vt[8]  = '{1'b0, 1'b0, FL, 1'b0, 3'd2, 6'b010000, 3'b100, 1};
        vt[9]  = '{1'b0, 1'b0, FL, 1'b0, 3'd3, 6'b000000, 3'b100, 1};
        vt[10] = '{1'b0, 1'b0, FR, 1'b0, 3'd4, 6'b000000, 3'b100, 1};
        vt[11] = '{1'b0, 1'b0, FR, 1'b0, 3'd5, 6'b000010, 3'b100, 1};
        vt[12] = '{1'b0, 1'b0, FR, 1'b0, 3'd5, 6'b000010, 3'b100, 1};
        vt[13] = '{1'b0, 1'b0, FR, 1'b0, 3'd5, 6'b000010, 3'b100, 1};
        vt[14] = '{1'b0, 1'b0, FR, 1'b1, 3'd5, 6'b000010, 3'b100, 1};
        vt[15] = '{1'b0, 1'b0, FR, 1'b0, 3'd6, 6'b001100, 3'b100, 1};
        vt[16] = '{1'b0, 1'b0, FR, 1'b0, 3'd2, 6'b010000, 3'b100, 2};

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rst, vt[i].g, vt[i].f, vt[i].mr);
            chk($sformatf("v%0d_state", i), int'(a_state), int'(vt[i].st));
            chk($sformatf("v%0d_strobes", i),
                int'({a_pc_init, a_ir_we, a_pc_we, a_rf_we, a_mem_re, a_mem_we}),
                int'(vt[i].sb));
            chk($sformatf("v%0d_bhe", i), int'({a_busy, a_halted, a_err}), int'(vt[i].bhe));
            chk($sformatf("v%0d_cnt", i), int'(a_cnt), vt[i].cnt);
        end
`ifdef Y_SEQ_PERF_EN
        chk("perf_stall_lw", int'(a_stall), 3);
        chk("perf_cyc_lw", int'(a_cyc), 12);
`endif

        // Store with mem_ready stuck low: 15 wait cycles then error halt
        drive(1'b1, 1'b0, FS, 1'b0);
        drive(1'b0, 1'b1, FS, 1'b0);
        repeat (4) drive(1'b0, 1'b0, FS, 1'b0);
        chk("t4_at_ex", int'(a_state), 4);
        memc = 0;
        wec  = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, FS, 1'b0);
            if (a_state != 3'd5) break;
            memc++;
            if (a_mem_we) wec++;
        end
        chk("t4_mem_cycles", memc, 15);
        chk("t4_mem_we_cycles", wec, 15);
        chk("t4_state_halt", int'(a_state), 7);
        chk("t4_err", int'(a_err), 1);
        chk("t4_mem_we_drop", int'(a_mem_we), 0);
        chk("t4_halted", int'(a_halted), 1);
        chk("t4_cnt", int'(a_cnt), 0);
`ifdef Y_SEQ_PERF_EN
        chk("t4_stall", int'(a_stall), 15);
`endif
        drive(1'b0, 1'b1, FS, 1'b1);
        chk("t4_go_ignored", int'(a_state), 7);
`ifdef Y_SEQ_PERF_EN
        chk("t4_stall_frozen", int'(a_stall), 15);
`endif

        // Illegal class at ID: none set, or two set
        pat[0] = FZ;
        pat[1] = F2;
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 1'b0, pat[p], 1'b0);
            drive(1'b0, 1'b1, pat[p], 1'b0);
            repeat (3) drive(1'b0, 1'b0, pat[p], 1'b0);
            chk($sformatf("t5_p%0d_at_id", p), int'(a_state), 3);
            drive(1'b0, 1'b0, pat[p], 1'b0);
            chk($sformatf("t5_p%0d_halt", p), int'(a_state), 7);
            chk($sformatf("t5_p%0d_err", p), int'(a_err), 1);
            chk($sformatf("t5_p%0d_cnt", p), int'(a_cnt), 0);
            drive(1'b0, 1'b1, FR, 1'b0);
            chk($sformatf("t5_p%0d_go_ignored", p), int'(a_halted), 1);
        end

        // Retire budget of 3 branches on the MAX_INS=3 instance
        drive(1'b1, 1'b0, FB, 1'b0);
        drive(1'b0, 1'b1, FB, 1'b0);
        drive(1'b0, 1'b0, FB, 1'b0);
        drive(1'b0, 1'b0, FB, 1'b0);
        chk("t6_first_if", int'(b_state), 2);
        cyc    = 1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 1'b0, FB, 1'b0);
            if (b_halted) break;
            cyc++;
            if (b_pc_we) pulses++;
        end
        chk("t6_cycles", cyc, 9);
        chk("t6_pc_we_pulses", pulses, 3);
        chk("t6_cnt", int'(b_cnt), 3);
        chk("t6_err", int'(b_err), 0);
        chk("t6_unlimited_state", int'(a_state), 2);
        chk("t6_unlimited_cnt", int'(a_cnt), 3);

        // Rerun, reset asserted during second EX
        drive(1'b1, 1'b0, FB, 1'b0);
        drive(1'b0, 1'b1, FB, 1'b0);
        repeat (7) drive(1'b0, 1'b0, FB, 1'b0);
        chk("t6_ex_state", int'(b_state), 4);
        chk("t6_ex_pc_we", int'(b_pc_we), 1);
        chk("t6_ex_cnt", int'(b_cnt), 1);
        drive(1'b1, 1'b0, FB, 1'b0);
        chk("t6_int_pc_we", int'(b_pc_we), 0);
        chk("t6_int_busy", int'(b_busy), 0);
        chk("t6_int_cnt", int'(b_cnt), 0);
        drive(1'b0, 1'b0, FB, 1'b0);
        chk("t6_idle", int'(b_state), 0);
        chk("t6_idle_cnt", int'(b_cnt), 0);
        chk("t6_idle_halted", int'(b_halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
